// File: rtl/ili9341_defs.sv
// Shared definitions for the ILI9341 8080-I write path: DCX levels,
// writer FSM states, FIFO entry layout and the panel command opcodes.
package ili9341_defs;

   localparam logic CD_CMD  = 1'b0;
   localparam logic CD_DATA = 1'b1;

   localparam logic [7:0] CMD_SWRESET = 8'h01;
   localparam logic [7:0] CMD_SLPOUT  = 8'h11;
   localparam logic [7:0] CMD_DISPON  = 8'h29;
   localparam logic [7:0] CMD_CASET   = 8'h2A;
   localparam logic [7:0] CMD_PASET   = 8'h2B;
   localparam logic [7:0] CMD_RAMWR   = 8'h2C;
   localparam logic [7:0] CMD_PIXFMT  = 8'h3A;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_WR_LOW,
      ST_WR_HIGH,
      ST_WAIT,
      ST_HOLD
   } state_t;

   typedef struct packed {
      logic       cd;
      logic       last;
      logic [7:0] data;
   } fifo_entry_t;

   // Largest of the four phase lengths; sizes the shared phase counter.
   function automatic int max_of4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags. Read data is the
// current head entry, valid whenever empty is low.
module sync_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic [AW:0]      count_next;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Occupancy after this cycle's push/pop, used to register the flags.
   always_comb begin
      count_next = count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
   end

   // Storage array; contents need no reset since empty guards the head.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // Pointers, occupancy and registered flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count_next;
         full  <= (count_next == (AW+1)'(DEPTH));
         empty <= (count_next == '0);
      end
   end

endmodule

// File: rtl/ili9341_bus_writer.sv
// 8080-I 8-bit write engine: bytes queued through a small FIFO are played
// out on CSX/DCX/WRX/D[7:0] with programmable setup, strobe and hold phases.
module ili9341_bus_writer
   import ili9341_defs::*;
#(
   parameter int FIFO_DEPTH      = 4,
   parameter int CS_SETUP_CYCLES = 1,
   parameter int WR_LOW_CYCLES   = 1,
   parameter int WR_HIGH_CYCLES  = 1,
   parameter int CS_HOLD_CYCLES  = 1
) (
   input  logic       in_clk,
   input  logic       in_rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_byte,
   input  logic       in_cd,
   input  logic       in_last,
   output logic       out_rd,
   output logic       out_wr,
   output logic       out_cd,
   output logic       out_cs,
   output logic [7:0] out_data,
   output logic       out_busy
);

   localparam int MAX_T = max_of4(CS_SETUP_CYCLES, WR_LOW_CYCLES, WR_HIGH_CYCLES, CS_HOLD_CYCLES);
   localparam int CW    = $clog2(MAX_T) + 1;

   state_t          state;
   state_t          state_next;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_next;
   logic            phase_done;
   logic            pop;
   logic            last_r;
   logic            fifo_full;
   logic            fifo_empty;
   logic [9:0]      fifo_wdata;
   logic [9:0]      fifo_rdata;
   fifo_entry_t     head;

   assign in_ready   = !fifo_full;
   assign out_rd     = 1'b1;
   assign out_busy   = (state != ST_IDLE) || !fifo_empty;
   assign fifo_wdata = {in_cd, in_last, in_byte};
   assign head       = fifo_rdata;
   assign phase_done = (cnt == '0);

   sync_fifo #(
      .WIDTH ($bits(fifo_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (in_clk),
      .rst   (in_rst),
      .push  (in_valid),
      .wdata (fifo_wdata),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Next state, FIFO pop and phase counter reload on every state change.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      cnt_next   = cnt;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               state_next = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (phase_done) state_next = ST_WR_LOW;
         end
         ST_WR_LOW: begin
            if (phase_done) state_next = ST_WR_HIGH;
         end
         ST_WR_HIGH: begin
            if (phase_done) begin
               if (last_r) begin
                  state_next = ST_HOLD;
               end else if (!fifo_empty) begin
                  pop        = 1'b1;
                  state_next = ST_WR_LOW;
               end else begin
                  state_next = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               state_next = ST_WR_LOW;
            end
         end
         ST_HOLD: begin
            if (phase_done) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase

      if (state_next != state) begin
         case (state_next)
            ST_SETUP:   cnt_next = CW'(CS_SETUP_CYCLES - 1);
            ST_WR_LOW:  cnt_next = CW'(WR_LOW_CYCLES - 1);
            ST_WR_HIGH: cnt_next = CW'(WR_HIGH_CYCLES - 1);
            ST_HOLD:    cnt_next = CW'(CS_HOLD_CYCLES - 1);
            default:    cnt_next = '0;
         endcase
      end else if (!phase_done) begin
         cnt_next = cnt - CW'(1);
      end
   end

   // State and phase counter registers.
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Panel pins registered from the next state so they line up with it;
   // data/cd only move on a pop, i.e. at SETUP entry or a WR fall.
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         out_cs   <= 1'b1;
         out_wr   <= 1'b1;
         out_cd   <= 1'b1;
         out_data <= 8'h00;
         last_r   <= 1'b0;
      end else begin
         out_cs <= (state_next == ST_IDLE);
         out_wr <= (state_next != ST_WR_LOW);
         if (pop) begin
            out_data <= head.data;
            out_cd   <= head.cd;
            last_r   <= head.last;
         end
      end
   end

endmodule

// File: doc/ili9341_bus_writer.md
Name: ili9341_bus_writer

Overview:
Byte-level 8080-I 8-bit write engine for the ILI9341 panel bus. Upstream controller logic (init sequencer, pixel fill) pushes command/data bytes through a valid/ready FIFO. This block turns each byte into correctly timed CSX/DCX/WRX/D[7:0] activity on the panel pins, driven by the 12 MHz board clock. RDX is held inactive; the block is write-only.

Parameters:
FIFO_DEPTH, 4, entries in the input byte FIFO; power of two, >=2
CS_SETUP_CYCLES, 1, cycles CS is low with data/cd valid before the first WR fall; >=1
WR_LOW_CYCLES, 1, cycles WR is held low per byte; >=1
WR_HIGH_CYCLES, 1, cycles WR is held high after each rising edge, with data held; >=1
CS_HOLD_CYCLES, 1, cycles CS stays low after the last byte's WR_HIGH phase; >=1

Ports:
in_clk  input  1  system clock
in_rst  input  1  reset
in_valid  input  1  upstream byte valid
in_ready  output  1  FIFO can accept; equals !fifo_full
in_byte  input  8  byte to write
in_cd  input  1  DCX level for this byte: 0 = command, 1 = data
in_last  input  1  release CS after this byte
out_rd  output  1  panel RDX, constant 1
out_wr  output  1  panel WRX
out_cd  output  1  panel DCX
out_cs  output  1  panel CSX
out_data  output  8  panel D[7:0]
out_busy  output  1  1 when FSM is not IDLE or FIFO is non-empty

Behaviour:
- One clock: in_clk. Reset is synchronous and active-high on in_rst.
- All panel outputs are registered.
- Reset values: out_cs=1, out_wr=1, out_rd=1, out_cd=1, out_data=8'h00, out_busy=0. FIFO is flushed, so in_ready=1 in the cycle after reset.
- Reset mid-transfer aborts immediately. Next cycle is IDLE with reset values; the partial byte is lost and no further WR edge is produced.
- Push: a byte is accepted when in_valid && in_ready. {in_cd, in_last, in_byte} is stored in the FIFO; order is preserved.
- FIFO empty/full flags are registered. Push while full cannot occur because in_ready=0. Pop only when not empty.
- FSM states:
  - IDLE: cs=1, wr=1. If FIFO is non-empty: pop, latch entry, drive data/cd, cs=0 -> SETUP.
  - SETUP: hold for CS_SETUP_CYCLES -> WR_LOW.
  - WR_LOW: wr=0 for WR_LOW_CYCLES -> WR_HIGH. The rising edge at exit is the panel latch point.
  - WR_HIGH: wr=1, data held, for WR_HIGH_CYCLES. Then:
    - latched last=1 -> HOLD;
    - else FIFO non-empty: pop, update data/cd -> WR_LOW;
    - else -> WAIT.
  - WAIT: cs=0, wr=1, data held. On FIFO non-empty: pop, update data/cd -> WR_LOW.
  - HOLD: cs=0, wr=1 for CS_HOLD_CYCLES -> IDLE, with cs=1 in the first IDLE cycle.
- Data and cd change only on the cycle WR falls, or on entry to SETUP. Both are stable through every WR rising edge.
- Latency: byte accepted in cycle N -> out_cs=0 with valid data in cycle N+2 (FIFO write at N, pop at N+1). With defaults, the first WR low is at N+3.
- Burst throughput: one byte per WR_LOW_CYCLES+WR_HIGH_CYCLES cycles, i.e. 2 with defaults (166 ns at 12 MHz; meets ILI9341 twc >= 66 ns).
- Phase counter width: $clog2(max of the timing parameters)+1. The counter reloads on each state entry.
- A byte without in_last, followed by an empty FIFO, leaves CS low in WAIT indefinitely; this is legal.

Decomposition:
- Shared include/package ili9341_defs: constants CD_CMD=1'b0 and CD_DATA=1'b1, the FSM state encodings, and the ILI9341 command opcodes used upstream (8'h01, 8'h11, 8'h29, 8'h2A, 8'h2B, 8'h2C, 8'h3A).
- One sub-module: sync_fifo (parameterised width 10, depth FIFO_DEPTH; registered full/empty). Instantiated once.

Test Plan:
1. Assert in_rst for 2 cycles -> out_cs=1, out_wr=1, out_rd=1, out_cd=1, out_data=00, in_ready=1, out_busy=0.
2. Single byte 8'h2C, cd=0, last=1, accepted at N (defaults) -> cs=0 and data=2C, cd=0 at N+2; wr=0 only at N+3; wr=1 at N+4, N+5; cs=1 at N+6; exactly one WR pulse.
3. Burst F8,00,F8,00 (cd=1, last on 4th) pushed back-to-back -> 4 WR pulses at a 2-cycle period; CS low continuously; bytes seen at each WR rise equal F8,00,F8,00.
4. WR_LOW_CYCLES=4, push 8 bytes with in_valid held -> in_ready drops once 4 entries are stored; all 8 bytes appear on out_data in order; none dropped or duplicated.
5. Byte 8'h2A, last=0, then 10 idle cycles, then 8'h00, last=1 -> CS stays low and WR high during the gap; second pulse follows; then CS rises.
6. Assert in_rst during WR_LOW of the 2nd byte of a burst -> next cycle wr=1, cs=1; after reset no WR edges occur; in_ready=1.
